// File: rtl/spart_pkg.sv
// -----------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the SPART processor-side driver:
//   ioaddr_e     - SPART register map as seen on ioaddr
//   drv_state_e  - driver state machine encoding
//   DIV_*        - baud divisors for a 50 MHz clk, selected by br_cfg
//   divisor_for  - br_cfg -> 16-bit divisor lookup
// -----------------------------------------------------------------------------
package spart_pkg;

    typedef enum logic [1:0] {
        BUF    = 2'b00,
        STATUS = 2'b01,
        DB_LO  = 2'b10,
        DB_HI  = 2'b11
    } ioaddr_e;

    typedef enum logic [2:0] {
        ST_CFG_LO = 3'd0,
        ST_CFG_HI = 3'd1,
        ST_IDLE   = 3'd2,
        ST_RD     = 3'd3,
        ST_WR     = 3'd4,
        ST_GAP    = 3'd5
    } drv_state_e;

    localparam logic [15:0] DIV_4800  = 16'h028A;
    localparam logic [15:0] DIV_9600  = 16'h0145;
    localparam logic [15:0] DIV_19200 = 16'h00A2;
    localparam logic [15:0] DIV_38400 = 16'h0050;

    localparam int ECHO_DEPTH = 4;
    localparam int ECHO_WIDTH = 8;

    function automatic logic [15:0] divisor_for(input logic [1:0] sel);
        logic [15:0] div;
        case (sel)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/spart_if.sv
// -----------------------------------------------------------------------------
// spart_if
// Control/status side of the SPART bus. The 8-bit databus is bidirectional
// and is carried as a separate inout wire next to this interface.
//   iocs   - chip select, one cycle per transaction
//   iorw   - 1 = read from SPART, 0 = write to SPART
//   ioaddr - register select (see spart_pkg::ioaddr_e)
//   rda    - SPART has received data available
//   tbr    - SPART transmit buffer ready
// -----------------------------------------------------------------------------
interface spart_if;
    import spart_pkg::*;

    logic    iocs;
    logic    iorw;
    ioaddr_e ioaddr;
    logic    rda;
    logic    tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_fifo.sv
// -----------------------------------------------------------------------------
// spart_fifo
// Small synchronous FIFO holding received bytes until they are echoed.
//   clk, rst  - clock and synchronous active-high reset
//   i_push    - write i_din (ignored when full)
//   i_pop     - drop the head entry (ignored when empty)
//   o_head    - registered copy of the head entry
//   o_full / o_empty / o_count - occupancy
// The head is a registered read: it reflects a push or pop one cycle later.
// The driver never issues back-to-back transactions (a GAP and an IDLE cycle
// always separate a push/pop from the next write), so the head is always
// settled when it is driven onto the bus.
// -----------------------------------------------------------------------------
module spart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
        r_head <= r_mem[r_rd_ptr];
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/spart_driver.sv
// -----------------------------------------------------------------------------
// spart_driver
// Processor-side initiator for a SPART: programs the baud divisor selected by
// br_cfg, then echoes every received byte back out through a 4-entry FIFO.
//   clk, rst    - clock, synchronous active-high reset
//   br_cfg      - baud select (00=4800, 01=9600, 10=19200, 11=38400)
//   bus         - spart_if master: iocs/iorw/ioaddr out, rda/tbr in
//   databus     - bidirectional data, driven only on write cycles
//   cfg_done    - divisor programmed for the current br_cfg
//   echo_level  - bytes currently held in the echo FIFO (0..4)
// -----------------------------------------------------------------------------
module spart_driver
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    spart_if.master    bus,
    inout  wire  [7:0] databus,
    output logic       cfg_done,
    output logic [2:0] echo_level
);

    localparam logic [2:0] CFG_LO = ST_CFG_LO;
    localparam logic [2:0] CFG_HI = ST_CFG_HI;
    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] RD     = ST_RD;
    localparam logic [2:0] WR     = ST_WR;
    localparam logic [2:0] GAP    = ST_GAP;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic        r_run;        // low for the reset cycles; keeps the bus idle
    logic [1:0]  r_br_cfg;     // registered br_cfg input
    logic [1:0]  r_cfg_cur;    // br_cfg the divisor is (being) programmed for
    logic        r_cfg_done;
    logic        w_cfg_changed;
    logic        w_reconfig;
    logic [15:0] w_divisor;

    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_fifo_head;
    logic [2:0]  w_fifo_count;

    logic        w_bus_active;
    logic        w_drive;
    logic [7:0]  w_wdata;

    assign w_cfg_changed = (r_br_cfg != r_cfg_cur);
    assign w_divisor     = divisor_for(r_cfg_cur);

    // Next-state logic. A br_cfg change is only acted on between
    // transactions (IDLE/GAP), so an in-flight RD/WR always completes.
    always_comb begin
        w_state_next = r_state;
        w_reconfig   = 1'b0;
        if (r_run) begin
            case (r_state)
                CFG_LO: w_state_next = CFG_HI;
                CFG_HI: w_state_next = GAP;
                IDLE: begin
                    if (w_cfg_changed) begin
                        w_reconfig   = 1'b1;
                        w_state_next = CFG_LO;
                    end else if (bus.rda && !w_fifo_full) begin
                        // Reads win so the SPART receiver never overruns.
                        w_state_next = RD;
                    end else if (bus.tbr && !w_fifo_empty) begin
                        w_state_next = WR;
                    end
                end
                RD:     w_state_next = GAP;
                WR:     w_state_next = GAP;
                GAP: begin
                    if (w_cfg_changed) begin
                        w_reconfig   = 1'b1;
                        w_state_next = CFG_LO;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = CFG_LO;
            endcase
        end
    end

    // r_br_cfg tracks the pin every cycle, including during reset, so the
    // divisor chosen at reset release is the one present during reset.
    always_ff @(posedge clk) begin
        r_br_cfg <= br_cfg;
        if (rst) begin
            r_state    <= CFG_LO;
            r_run      <= 1'b0;
            r_cfg_cur  <= br_cfg;
            r_cfg_done <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_next;
            if (w_reconfig) begin
                r_cfg_cur  <= r_br_cfg;
                r_cfg_done <= 1'b0;
            end else if (r_run && (r_state == CFG_HI)) begin
                r_cfg_done <= 1'b1;
            end
        end
    end

    // Bus decode is purely from registered state, so outputs are glitch-free
    // relative to the clock and stay idle while r_run is low.
    always_comb begin
        w_bus_active = 1'b0;
        w_drive      = 1'b0;
        w_wdata      = w_fifo_head;
        bus.ioaddr   = BUF;
        if (r_run) begin
            case (r_state)
                CFG_LO: begin
                    w_bus_active = 1'b1;
                    w_drive      = 1'b1;
                    w_wdata      = w_divisor[7:0];
                    bus.ioaddr   = DB_LO;
                end
                CFG_HI: begin
                    w_bus_active = 1'b1;
                    w_drive      = 1'b1;
                    w_wdata      = w_divisor[15:8];
                    bus.ioaddr   = DB_HI;
                end
                RD: begin
                    w_bus_active = 1'b1;
                end
                WR: begin
                    w_bus_active = 1'b1;
                    w_drive      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.iocs = w_bus_active;
    assign bus.iorw = ~w_drive;
    assign databus  = w_drive ? w_wdata : 8'hzz;

    assign w_push = r_run && (r_state == RD);
    assign w_pop  = r_run && (r_state == WR);

    spart_fifo #(
        .DEPTH (ECHO_DEPTH),
        .WIDTH (ECHO_WIDTH)
    ) u_echo_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (databus),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign cfg_done   = r_cfg_done;
    assign echo_level = w_fifo_count;

endmodule

// File: doc/spart_driver.md
SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port br_cfg, input, 2 bits: baud select; 00=4800, 01=9600, 10=19200, 11=38400.
REQ-004 SHALL have port rda, input, 1 bit: SPART receive data available.
REQ-005 SHALL have port tbr, input, 1 bit: SPART transmit buffer ready.
REQ-006 SHALL have port iocs, output, 1 bit: SPART chip select, high for exactly one cycle per bus transaction.
REQ-007 SHALL have port iorw, output, 1 bit: 1=read from SPART, 0=write to SPART.
REQ-008 SHALL have port ioaddr, output, 2 bits: 00=TX/RX buffer, 01=status, 10=divisor low byte, 11=divisor high byte.
REQ-009 SHALL have port databus, inout, 8 bits: driven only during write cycles, high-Z otherwise.
REQ-010 SHALL have port cfg_done, output, 1 bit: divisor programmed for the current br_cfg.
REQ-011 SHALL have port echo_level, output, 3 bits: number of bytes held in the echo buffer (0..4).

Function
REQ-012 SHALL function as the processor-side initiator for the SPART: programs the baud divisor, then echoes every received byte back out.
REQ-013 SHALL map the divisor per br_cfg at a 50 MHz clk: 00->0x028A, 01->0x0145, 10->0x00A2, 11->0x0050.
REQ-014 SHALL implement the states CFG_LO, CFG_HI, IDLE, RD, WR and GAP.
REQ-015 CFG_LO SHALL do: iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0]; next state CFG_HI.
REQ-016 CFG_HI SHALL do: iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8]; next state GAP; cfg_done=1 from the following cycle.
REQ-017 IDLE SHALL do: if rda=1 and the buffer is not full, go to RD; else if tbr=1 and the buffer is not empty, go to WR; else stay.
REQ-018 IDLE priority SHALL favour reads over writes when both are eligible, to avoid receiver overrun.
REQ-019 RD SHALL do: iocs=1, iorw=1, ioaddr=00; sample databus at the end of the cycle and push it into the buffer; next state GAP.
REQ-020 WR SHALL do: iocs=1, iorw=0, ioaddr=00, databus=buffer head; pop at the end of the cycle; next state GAP.
REQ-021 GAP SHALL be one bus-idle cycle with iocs=0, so the SPART can update rda/tbr; next state IDLE.
REQ-022 Bus timing SHALL be no back-to-back iocs cycles except CFG_LO->CFG_HI, and at most one transaction per cycle.
REQ-023 br_cfg SHALL be registered; a change observed in IDLE or GAP SHALL clear cfg_done and re-enter CFG_LO.
REQ-024 A br_cfg change during RD or WR SHALL let that transaction finish first; buffer contents are preserved.
REQ-025 The buffer SHALL be a 4-entry FIFO.
REQ-026 When the buffer is full, rda SHALL be ignored (no read issued) until a WR frees an entry.
REQ-027 When the buffer is empty, tbr SHALL be ignored.
REQ-028 FIFO pointers SHALL be 2 bits wrapping 3->0; echo_level SHALL be a 3-bit count, never above 4 or below 0.
REQ-029 RD and WR SHALL never occur in the same cycle.
REQ-030 databus SHALL be high-Z in every state with iorw=1 or iocs=0.

Reset
REQ-031 While rst=1, the block SHALL set state=CFG_LO, iocs=0, iorw=1, ioaddr=00, databus high-Z, cfg_done=0, echo_level=0, and clear the FIFO pointers.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction and discard buffered bytes.
REQ-033 After rst deasserts, the first bus cycle SHALL be CFG_LO on the next clk edge.

Structure
REQ-034 Package spart_pkg SHALL hold the ioaddr enum (BUF, STATUS, DB_LO, DB_HI), the driver state enum, and the four divisor constants indexed by br_cfg.
REQ-035 The FIFO SHALL be a sub-module spart_fifo (parameterised depth/width, push/pop/full/empty/count).
REQ-036 The state machine, tri-state control and br_cfg change detection SHALL stay in spart_driver.

Verification
REQ-037 Scenario: rst for 2 cycles, br_cfg=01 -> write DB_LO 0x45, write DB_HI 0x01, then cfg_done=1, iocs low in the GAP cycle.
REQ-038 Scenario: rda pulse with SPART byte 0x5A, tbr=1 -> RD at addr 00, GAP, WR at addr 00 with databus=0x5A, echo_level 0->1->0.
REQ-039 Scenario: tbr=0 while 5 bytes 0x01..0x05 arrive -> 4 reads, echo_level=4, 5th rda ignored; tbr=1 -> writes 0x01,0x02,0x03,0x04 in order.
REQ-040 Scenario: rda=1 and tbr=1 with 1 byte buffered -> RD issued before WR; no cycle with two transactions.
REQ-041 Scenario: br_cfg 01->11 while idle -> cfg_done drops, writes 0x50 then 0x00, buffered bytes unchanged.
REQ-042 Scenario: rst asserted during WR -> next cycle iocs=0, databus high-Z, echo_level=0, then reconfiguration is sequenced.
